// File: rtl/ppa_pkg.sv
// ppa_pkg: generate/propagate type, prefix operator and level-split helpers for pipelined_prefix_adder
package ppa_pkg;
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
  function automatic gp_t gp_combine(gp_t hi, gp_t lo);
    return '{g: hi.g | (hi.p & lo.g), p: hi.p & lo.p};
  endfunction
  function automatic int ppa_levels(int width);
    return $clog2(width);
  endfunction
  function automatic int ppa_group_levels(int l, int stages, int k);
    return stages < 1 ? 0 : (k < l % stages) ? l / stages + 1 : l / stages;
  endfunction
  function automatic int ppa_group_start(int l, int stages, int k);
    int s = 0;
    for (int i = 0; i < k; i++) s += ppa_group_levels(l, stages, i);
    return s;
  endfunction
endpackage

// File: rtl/prefix_gp_level.sv
// prefix_gp_level: one combinational Kogge-Stone level, bit i combines with bit i-SPAN
module prefix_gp_level
  import ppa_pkg::*;
#(
  parameter int WIDTH = 21,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= SPAN) begin : g_op
      assign {g_o[i], p_o[i]} = gp_combine({g_i[i], p_i[i]}, {g_i[i-SPAN], p_i[i-SPAN]});
    end else begin : g_pass
      assign {g_o[i], p_o[i]} = {g_i[i], p_i[i]};
    end
  end
endmodule

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: pipelined Kogge-Stone add/sub with valid/ready; PPA_FLAGS_EN adds out_zero/out_ovf
module pipelined_prefix_adder
  import ppa_pkg::*;
#(
  parameter int WIDTH  = 21,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef PPA_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_ovf
`endif
);
  localparam int L = ppa_levels(WIDTH);
  if (WIDTH < 2 || STAGES < 1 || STAGES > L) begin : g_bad
    $error("pipelined_prefix_adder: illegal WIDTH=%0d STAGES=%0d (levels=%0d)", WIDTH, STAGES, L);
  end
  logic adv, c0;
  logic [WIDTH-1:0] b_x, g_in, p_in;
  logic [WIDTH-1:0] g_d [STAGES];
  logic [WIDTH-1:0] g_q [STAGES];
  logic [WIDTH-1:0] p_d [STAGES];
  logic [WIDTH-1:0] p_q [STAGES];
  logic [WIDTH-1:0] x_d [STAGES];
  logic [WIDTH-1:0] x_q [STAGES];
  logic [STAGES-1:0] c0_d, c0_q, v_d, v_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic cout_d, cout_q;
`ifdef PPA_FLAGS_EN
  logic zero_d, zero_q, ovf_d, ovf_q;
  assign out_zero = zero_q;
  assign out_ovf  = ovf_q;
`endif
  always_comb begin
    adv  = ~v_q[STAGES-1] | out_ready;
    b_x  = in_b ^ {WIDTH{in_sub}};
    c0   = in_sub | in_cin;
    p_in = in_a ^ b_x;
    g_in = (in_a & b_x) | {{(WIDTH-1){1'b0}}, p_in[0] & c0};
  end
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int N  = ppa_group_levels(L, STAGES, k);
    localparam int S0 = ppa_group_start(L, STAGES, k);
    logic [WIDTH-1:0] g_l [N+1];
    logic [WIDTH-1:0] p_l [N+1];
    logic [WIDTH-1:0] x_l;
    logic c0_l, v_l;
    if (k == 0) begin : g_src
      assign g_l[0] = g_in;
      assign p_l[0] = p_in;
      assign x_l    = p_in;
      assign c0_l   = c0;
      assign v_l    = in_valid & adv;
    end else begin : g_src
      assign g_l[0] = g_q[k-1];
      assign p_l[0] = p_q[k-1];
      assign x_l    = x_q[k-1];
      assign c0_l   = c0_q[k-1];
      assign v_l    = v_q[k-1];
    end
    for (genvar j = 0; j < N; j++) begin : g_lvl
      prefix_gp_level #(.WIDTH(WIDTH), .SPAN(1 << (S0 + j))) u_lvl (
        .g_i(g_l[j]),
        .p_i(p_l[j]),
        .g_o(g_l[j+1]),
        .p_o(p_l[j+1])
      );
    end
    if (k < STAGES - 1) begin : g_mid
      assign g_d[k]  = adv ? g_l[N] : g_q[k];
      assign p_d[k]  = adv ? p_l[N] : p_q[k];
      assign x_d[k]  = adv ? x_l : x_q[k];
      assign c0_d[k] = adv ? c0_l : c0_q[k];
    end else begin : g_fin
      logic [WIDTH-1:0] s;
      assign s      = x_l ^ {g_l[N][WIDTH-2:0], c0_l};
      assign sum_d  = adv ? s : sum_q;
      assign cout_d = adv ? g_l[N][WIDTH-1] : cout_q;
`ifdef PPA_FLAGS_EN
      assign zero_d = adv ? ~|s : zero_q;
      assign ovf_d  = adv ? g_l[N][WIDTH-2] ^ g_l[N][WIDTH-1] : ovf_q;
`endif
    end
    assign v_d[k] = adv ? v_l : v_q[k];
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES - 1; k++) begin
      g_q[k]  <= g_d[k];
      p_q[k]  <= p_d[k];
      x_q[k]  <= x_d[k];
      c0_q[k] <= c0_d[k];
    end
    v_q    <= rst ? '0 : v_d;
    sum_q  <= rst ? '0 : sum_d;
    cout_q <= rst ? 1'b0 : cout_d;
`ifdef PPA_FLAGS_EN
    zero_q <= rst ? 1'b0 : zero_d;
    ovf_q  <= rst ? 1'b0 : ovf_d;
`endif
  end
endmodule
